// File: rtl/video_pkg.sv
// Shared video types: display modes, RGB888 pixel struct and fixed overlay colours.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'd0,
    MODE_GRID = 2'd1,
    MODE_ZOOM = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam rgb888_t COL_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb888_t COL_GREEN = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb888_t COL_RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/grid_overlay_renderer_if.sv
// Pixel stream, cursor commands and overlay results of grid_overlay_renderer.
// master: pixel source / command issuer; slave: the renderer.
interface grid_overlay_renderer_if #(
  parameter int unsigned GRID_N = 4
);
  localparam int unsigned CW = $clog2(GRID_N * GRID_N);

  logic [9:0]    x;
  logic [9:0]    y;
  logic          de;
  logic [1:0]    mode;
  logic          mv_left;
  logic          mv_right;
  logic          mv_up;
  logic          mv_down;
  logic          sel;
  logic [23:0]   data_ram;
  logic [23:0]   data_interp;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic [CW-1:0] pos_cursor;
  logic [CW-1:0] sel_tile;
  logic          sel_valid;

  modport master (
    output x, y, de, mode, mv_left, mv_right, mv_up, mv_down, sel, data_ram, data_interp,
    input  red, green, blue, pos_cursor, sel_tile, sel_valid
  );

  modport slave (
    input  x, y, de, mode, mv_left, mv_right, mv_up, mv_down, sel, data_ram, data_interp,
    output red, green, blue, pos_cursor, sel_tile, sel_valid
  );

endinterface

// File: rtl/grid_cursor_ctrl.sv
// Cursor row/col registers with wrap-around moves, selection latch and
// (with GRID_OVERLAY_BLINK_EN defined) the frame-based blink counter.
module grid_cursor_ctrl #(
  parameter int unsigned GRID_N       = 4,
  parameter int unsigned BLINK_FRAMES = 30,
  localparam int unsigned CW = $clog2(GRID_N * GRID_N),
  localparam int unsigned RW = $clog2(GRID_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_en,
  input  logic          mv_left,
  input  logic          mv_right,
  input  logic          mv_up,
  input  logic          mv_down,
  input  logic          sel,
`ifdef GRID_OVERLAY_BLINK_EN
  input  logic          frame_start,
`endif
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic [CW-1:0] pos_cursor,
  output logic [CW-1:0] sel_tile,
  output logic          sel_valid,
  output logic          cur_visible
);

  localparam logic [RW-1:0] LAST = RW'(GRID_N - 1);

  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic [CW-1:0] sel_tile_q;
  logic          sel_valid_q;
  logic          moved;

  // Next cursor position: one move per cycle, left > right > up > down.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    moved = 1'b0;
    if (cmd_en) begin
      if (mv_left) begin
        col_d = (col_q == '0) ? LAST : col_q - 1'b1;
        moved = 1'b1;
      end else if (mv_right) begin
        col_d = (col_q == LAST) ? '0 : col_q + 1'b1;
        moved = 1'b1;
      end else if (mv_up) begin
        row_d = (row_q == '0) ? LAST : row_q - 1'b1;
        moved = 1'b1;
      end else if (mv_down) begin
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
        moved = 1'b1;
      end
    end
  end

  // Cursor and selection registers; sel captures the pre-move position.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      sel_tile_q  <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (cmd_en && sel) begin
        sel_tile_q  <= pos_cursor;
        sel_valid_q <= 1'b1;
      end
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign pos_cursor = CW'(32'(row_q) * GRID_N + 32'(col_q));
  assign sel_tile   = sel_tile_q;
  assign sel_valid  = sel_valid_q;

`ifdef GRID_OVERLAY_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          visible_q, visible_d;

  // Blink phase: a move restarts the visible phase, otherwise count frames.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    if (moved) begin
      frame_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (frame_start) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
    end
  end

  assign cur_visible = visible_q;
`else
  assign cur_visible = 1'b1;
`endif

endmodule

// File: rtl/grid_overlay_renderer.sv
// Two-stage pixel compositor drawing a tile grid, a cursor box and a zoom
// window over an RGB888 stream. Cursor blink is built only when the macro
// GRID_OVERLAY_BLINK_EN is defined.
module grid_overlay_renderer
  import video_pkg::*;
#(
  parameter int unsigned IMG_X0       = 120,
  parameter int unsigned IMG_Y0       = 40,
  parameter int unsigned TILE_PX      = 100,
  parameter int unsigned GRID_N       = 4,
  parameter int unsigned CUR_INSET    = 25,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  grid_overlay_renderer_if.slave    bus
);

  localparam int unsigned CW    = $clog2(GRID_N * GRID_N);
  localparam int unsigned RW    = $clog2(GRID_N);
  localparam int unsigned IMG_W = GRID_N * TILE_PX;

  // Elaboration-time parameter sanity checks.
  if (GRID_N < 2 || GRID_N > 8) begin : g_bad_grid_n
    $error("GRID_N must be in 2..8");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  logic [RW-1:0] row, col;
  logic [CW-1:0] pos_cursor, sel_tile;
  logic          sel_valid, cur_visible, cmd_en;

  assign cmd_en = (mode_e'(bus.mode) != MODE_ZOOM);

`ifdef GRID_OVERLAY_BLINK_EN
  logic at_origin, at_origin_q, frame_start;

  assign at_origin   = (bus.x == '0) && (bus.y == '0);
  assign frame_start = at_origin && !at_origin_q;

  // Remember whether the previous pixel was the origin.
  always_ff @(posedge clk) begin
    if (reset) at_origin_q <= 1'b0;
    else       at_origin_q <= at_origin;
  end
`endif

  grid_cursor_ctrl #(
    .GRID_N      (GRID_N),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_cursor (
    .clk        (clk),
    .reset      (reset),
    .cmd_en     (cmd_en),
    .mv_left    (bus.mv_left),
    .mv_right   (bus.mv_right),
    .mv_up      (bus.mv_up),
    .mv_down    (bus.mv_down),
    .sel        (bus.sel),
`ifdef GRID_OVERLAY_BLINK_EN
    .frame_start(frame_start),
`endif
    .row        (row),
    .col        (col),
    .pos_cursor (pos_cursor),
    .sel_tile   (sel_tile),
    .sel_valid  (sel_valid),
    .cur_visible(cur_visible)
  );

  assign bus.pos_cursor = pos_cursor;
  assign bus.sel_tile   = sel_tile;
  assign bus.sel_valid  = sel_valid;

  // Stage 1: classify the incoming pixel against image, grid, cursor and zoom regions.
  int unsigned px, py, box_x0, box_y0;
  logic        in_img, on_line, in_box, in_zoom;

  always_comb begin
    px      = 32'(bus.x);
    py      = 32'(bus.y);
    in_img  = (px >= IMG_X0) && (px <= IMG_X0 + IMG_W) &&
              (py >= IMG_Y0) && (py <= IMG_Y0 + IMG_W);
    on_line = 1'b0;
    for (int unsigned k = 1; k < GRID_N; k++) begin
      if (px == IMG_X0 + k * TILE_PX || py == IMG_Y0 + k * TILE_PX) on_line = 1'b1;
    end
    box_x0  = IMG_X0 + 32'(col) * TILE_PX;
    box_y0  = IMG_Y0 + 32'(row) * TILE_PX;
    in_box  = cur_visible &&
              (px >= box_x0 + CUR_INSET) && (px <= box_x0 + TILE_PX - CUR_INSET) &&
              (py >= box_y0 + CUR_INSET) && (py <= box_y0 + TILE_PX - CUR_INSET);
    in_zoom = (px >= IMG_X0 + TILE_PX) && (px <= IMG_X0 + (GRID_N - 1) * TILE_PX) &&
              (py >= IMG_Y0 + TILE_PX) && (py <= IMG_Y0 + (GRID_N - 1) * TILE_PX);
  end

  logic    s1_vis_q, s1_line_q, s1_box_q, s1_zoom_q;
  mode_e   s1_mode_q;
  rgb888_t s1_ram_q, s1_interp_q;

  // Stage 1 registers; de and region gate collapse into one visibility bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vis_q    <= 1'b0;
      s1_line_q   <= 1'b0;
      s1_box_q    <= 1'b0;
      s1_zoom_q   <= 1'b0;
      s1_mode_q   <= MODE_RAW;
      s1_ram_q    <= COL_BLACK;
      s1_interp_q <= COL_BLACK;
    end else begin
      s1_vis_q    <= bus.de && in_img;
      s1_line_q   <= on_line;
      s1_box_q    <= in_box;
      s1_zoom_q   <= in_zoom;
      s1_mode_q   <= mode_e'(bus.mode);
      s1_ram_q    <= rgb888_t'(bus.data_ram);
      s1_interp_q <= rgb888_t'(bus.data_interp);
    end
  end

  // Stage 2: pick the output colour; cursor overrides grid lines.
  rgb888_t rgb_d, rgb_q;

  always_comb begin
    rgb_d = COL_BLACK;
    if (s1_vis_q) begin
      unique case (s1_mode_q)
        MODE_RAW:  rgb_d = s1_ram_q;
        MODE_GRID: rgb_d = s1_box_q ? COL_RED : (s1_line_q ? COL_GREEN : s1_ram_q);
        MODE_ZOOM: rgb_d = s1_zoom_q ? s1_interp_q : COL_BLACK;
        MODE_RSVD: rgb_d = COL_BLACK;
      endcase
    end
  end

  // Output colour register.
  always_ff @(posedge clk) begin
    if (reset) rgb_q <= COL_BLACK;
    else       rgb_q <= rgb_d;
  end

  assign bus.red   = rgb_q.r;
  assign bus.green = rgb_q.g;
  assign bus.blue  = rgb_q.b;

endmodule
